fifo_uart_tx: RTL and testbench

- Consumer end of the fifo push/pop interface. Drains bytes from a first-word-fall-through FIFO read port (empty, pop, pop_data) and serializes each byte as a UART 8N1 frame on tx.
- Sits between the FIFO and the board TX pin; the upstream logic only pushes, and this block does all popping.

---
 rtl/fifo_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a FWFT FIFO and serialises each byte as a UART 8N1 frame
// Optional even parity bit between data and stop: define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] pop_data,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            pop_q, pop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            bit_end;
  logic [2:0]      bit_nxt;

  assign bit_end = (tick_q == TICK_LAST);
  assign bit_nxt = bit_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        tick_d = '0;
        bit_d  = 3'd0;
        // The byte is captured together with the pop, so later pop_data changes cannot leak in.
        if (tx_en && !empty) begin
          shift_d = pop_data;
          pop_d   = 1'b1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          tick_d = '0;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif

      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          tick_d  = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: begin
        tick_d  = '0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop     = pop_q;
  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed self-checking bench for fifo_uart_tx (CLKS_PER_BIT=16)
module tb_fifo_uart_tx;

  localparam int CPB = 16;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       empty;
  logic [7:0] pop_data;
  logic       pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int         checks;
  int         failures;
  int         pop_total;
  bit         use_fifo;
  logic [7:0] q[$];
  logic [10:0] last_obs;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_en    (tx_en),
    .empty    (empty),
    .pop_data (pop_data),
    .pop      (pop),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; the FIFO model consumes a byte when it sees pop.
  task automatic tick();
    logic [7:0] dropped;
    @(negedge clk);
    if (pop === 1'b1) pop_total++;
    if (use_fifo) begin
      if (pop === 1'b1 && q.size() > 0) dropped = q.pop_front();
      empty    = (q.size() == 0);
      pop_data = (q.size() > 0) ? q[0] : 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    empty    = 1'b0;
    pop_data = q[0];
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    tick();
    while (tx !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_start_seen"}, 32'(tx === 1'b0), 32'(1));
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Entered on cycle 0 of a frame (first tx-low cycle); leaves on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input int drop_en_at, input string tag);
    logic [10:0] expv, obsv;
    int glitches, busy_bad, pops_seen, done_seen;
    logic pop_c0;
    expv = '0;
    obsv = '0;
    glitches = 0; busy_bad = 0; pops_seen = 0; done_seen = 0;
    pop_c0 = pop;
    for (int k = 0; k < NB; k++) expv[k] = exp_bit(b, k);
    for (int c = 0; c < NB*CPB; c++) begin
      if (c > 0) tick();
      if (c == drop_en_at) tx_en = 1'b0;
      if (tx !== exp_bit(b, c / CPB)) glitches++;
      if ((c % CPB) == CPB/2) obsv[c / CPB] = tx;
      if (tx_busy !== 1'b1) busy_bad++;
      if (pop === 1'b1) pops_seen++;
      if (tx_done === 1'b1) done_seen++;
    end
    chk({tag, "_bits"}, 32'(obsv), 32'(expv));
    chk({tag, "_bad_cycles"}, 32'(glitches), 32'(0));
    chk({tag, "_busy_drop"}, 32'(busy_bad), 32'(0));
    chk({tag, "_pop_c0"}, 32'(pop_c0), 32'(1));
    chk({tag, "_pops"}, 32'(pops_seen), 32'(1));
    chk({tag, "_early_done"}, 32'(done_seen), 32'(0));
    tick();
    chk({tag, "_end_done_busy_tx"}, 32'({tx_done, tx_busy, tx}), 32'(3'b101));
    last_obs = obsv;
  endtask

  initial begin
    int lows, pops;
    checks = 0; failures = 0; pop_total = 0; use_fifo = 1'b0;
    rst = 1'b1; tx_en = 1'b1; empty = 1'b0; pop_data = 8'hA5;

    // Reset held three cycles with a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", 32'({tx, pop, tx_busy, tx_done}), 32'(4'b1000));
    end
    empty = 1'b1;
    rst   = 1'b0;
    lows = 0; pop_total = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk("idle_empty_pops", 32'(pop_total), 32'(0));
    chk("idle_empty_tx_low", 32'(lows), 32'(0));

    // Single byte driven directly; pop_data is changed after the pop to prove it is latched
    pop_data = 8'hA5;
    empty    = 1'b0;
    wait_start("a5");
    empty    = 1'b1;
    pop_data = 8'h00;
    check_frame(8'hA5, -1, "a5");
    tick();
    chk("a5_done_one_cycle", 32'({tx_done, pop, tx}), 32'(3'b001));

    // Back-to-back through the FIFO model
    use_fifo  = 1'b1;
    pop_total = 0;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_start("b0");
    check_frame(8'h00, -1, "b0");
    tick();
    chk("b1_gap", 32'({tx, pop}), 32'(2'b01));
    check_frame(8'hFF, -1, "b1");
    tick();
    chk("b2_gap", 32'({tx, pop}), 32'(2'b01));
    check_frame(8'h3C, -1, "b2");
    chk("b_empty_after", 32'(empty), 32'(1));
    for (int i = 0; i < 50; i++) tick();
    chk("b_total_pops", 32'(pop_total), 32'(3));

    // tx_en dropped mid-frame, then restored
    push(8'h55); push(8'h99);
    wait_start("en55");
    check_frame(8'h55, 50, "en55");
    lows = 0; pop_total = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk("en_off_pops", 32'(pop_total), 32'(0));
    chk("en_off_tx_low", 32'(lows), 32'(0));
    chk("en_off_nonempty", 32'(empty), 32'(0));
    tx_en = 1'b1;
    tick();
    chk("en_on_pop", 32'({pop, tx}), 32'(2'b10));
    check_frame(8'h99, -1, "en99");

    // Reset during data bit 3 of 0xC3; the next byte must follow, not a resend
    push(8'hC3); push(8'h5A);
    wait_start("rc3");
    for (int i = 0; i < 70; i++) tick();
    chk("rc3_mid_busy", 32'(tx_busy), 32'(1));
    rst = 1'b1;
    tick();
    chk("rc3_reset_outs", 32'({tx, tx_busy, tx_done, pop}), 32'(4'b1000));
    rst = 1'b0;
    wait_start("r5a");
    check_frame(8'h5A, -1, "r5a");

    // Parity-relevant bytes (parity bit checked when the feature is built in)
    push(8'h07); push(8'h03);
    wait_start("p07");
    check_frame(8'h07, -1, "p07");
`ifdef FIFO_UART_TX_PARITY_EN
    chk("p07_parity_bit", 32'(last_obs[9]), 32'(1));
`endif
    tick();
    chk("p03_gap", 32'(tx), 32'(0));
    check_frame(8'h03, -1, "p03");
`ifdef FIFO_UART_TX_PARITY_EN
    chk("p03_parity_bit", 32'(last_obs[9]), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
